gelato_simt_stack: RTL and testbench

GELATO_SIMT_STACK -- requirements
Module: gelato_simt_stack

---
 rtl/gelato_macros.sv | 9 +
 rtl/gelato_types.sv | 20 ++
 rtl/gelato_warp_simt_stack.sv | 120 ++++++++++++
 rtl/gelato_simt_stack.sv | 96 +++++++++
 tb/tb_gelato_simt_stack.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/gelato_macros.sv
// Default parameter values shared by the SIMT reconvergence stack blocks.
package gelato_macros;

   localparam int unsigned GELATO_WARP_NUM    = 4;
   localparam int unsigned GELATO_THREAD_NUM  = 32;
   localparam int unsigned GELATO_STACK_DEPTH = 8;
   localparam int unsigned GELATO_PC_WIDTH    = 32;

endpackage

// File: rtl/gelato_types.sv
// Operation encoding and stack entry layout for the SIMT reconvergence stack.
package gelato_types;

   import gelato_macros::*;

   typedef enum logic [1:0] {
      SIMT_NOP     = 2'd0,
      SIMT_ADVANCE = 2'd1,
      SIMT_BRANCH  = 2'd2,
      SIMT_EXIT    = 2'd3
   } simt_op_t;

   // Fields are sized to the shared defaults; instances narrow them with casts.
   typedef struct packed {
      logic [GELATO_PC_WIDTH-1:0]   pc;
      logic [GELATO_THREAD_NUM-1:0] mask;
      logic [GELATO_PC_WIDTH-1:0]   rpc;
   } simt_entry_t;

endpackage

// File: rtl/gelato_warp_simt_stack.sv
// Reconvergence stack for one warp: registered top-of-stack plus a register
// array holding the entries underneath it.
module gelato_warp_simt_stack
   import gelato_macros::*;
   import gelato_types::*;
#(
   parameter  int unsigned STACK_DEPTH = GELATO_STACK_DEPTH,
   parameter  int unsigned THREAD_NUM  = GELATO_THREAD_NUM,
   parameter  int unsigned PC_WIDTH    = GELATO_PC_WIDTH,
   localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rdy,
   input  logic                  init_valid,
   input  logic [PC_WIDTH-1:0]   init_pc,
   input  logic [THREAD_NUM-1:0] init_mask,
   input  logic                  upd_valid,
   input  simt_op_t              upd_op,
   input  logic [PC_WIDTH-1:0]   upd_pc,
   input  logic [PC_WIDTH-1:0]   upd_taken_pc,
   input  logic [THREAD_NUM-1:0] upd_taken_mask,
   input  logic [PC_WIDTH-1:0]   upd_reconv_pc,
   output logic                  valid,
   output logic [PC_WIDTH-1:0]   pc,
   output logic [THREAD_NUM-1:0] mask,
   output logic [DEPTH_W-1:0]    depth,
   output logic                  overflow_c
);

   localparam int unsigned LOW_NUM = STACK_DEPTH - 1;
   localparam int unsigned IDX_W   = $clog2(LOW_NUM);
   localparam int unsigned EPC_W   = GELATO_PC_WIDTH;
   localparam int unsigned EMASK_W = GELATO_THREAD_NUM;

   simt_entry_t          tos_q, tos_d;
   simt_entry_t          stk_q [LOW_NUM];
   simt_entry_t          stk_d [LOW_NUM];
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic                 valid_q, valid_d;
   logic [EMASK_W-1:0]   tmask, taken, fall;
   logic [EPC_W-1:0]     npc, tpc, rpc;
   logic [IDX_W-1:0]     lo_idx, hi_idx, pop_idx;

   // Next-state: init beats update; stack below TOS grows upward from index 0.
   always_comb begin
      tos_d      = tos_q;
      stk_d      = stk_q;
      depth_d    = depth_q;
      valid_d    = valid_q;
      overflow_c = 1'b0;
      tmask      = EMASK_W'(upd_taken_mask);
      taken      = tos_q.mask & tmask;
      fall       = tos_q.mask & ~tmask;
      npc        = EPC_W'(upd_pc);
      tpc        = EPC_W'(upd_taken_pc);
      rpc        = EPC_W'(upd_reconv_pc);
      lo_idx     = IDX_W'(depth_q - DEPTH_W'(1));
      hi_idx     = IDX_W'(depth_q);
      pop_idx    = IDX_W'(depth_q - DEPTH_W'(2));
      if (rdy) begin
         if (init_valid && (init_mask != '0)) begin
            tos_d   = '{pc: EPC_W'(init_pc), mask: EMASK_W'(init_mask), rpc: '1};
            depth_d = DEPTH_W'(1);
            valid_d = 1'b1;
         end else if (upd_valid && valid_q) begin
            case (upd_op)
               SIMT_ADVANCE: begin
                  if ((depth_q > DEPTH_W'(1)) && (npc == tos_q.rpc)) begin
                     tos_d   = stk_q[pop_idx];
                     depth_d = depth_q - DEPTH_W'(1);
                  end else begin
                     tos_d.pc = npc;
                  end
               end
               SIMT_BRANCH: begin
                  if (taken == '0) begin
                     tos_d.pc = npc;
                  end else if (fall == '0) begin
                     tos_d.pc = tpc;
                  end else if ((32'(depth_q) + 32'd2) > STACK_DEPTH) begin
                     overflow_c = 1'b1;
                  end else begin
                     stk_d[lo_idx] = '{pc: rpc, mask: tos_q.mask, rpc: tos_q.rpc};
                     stk_d[hi_idx] = '{pc: npc, mask: fall, rpc: rpc};
                     tos_d         = '{pc: tpc, mask: taken, rpc: rpc};
                     depth_d       = depth_q + DEPTH_W'(2);
                  end
               end
               SIMT_EXIT: begin
                  tos_d   = '0;
                  depth_d = '0;
                  valid_d = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tos_q   <= '0;
         depth_q <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < int'(LOW_NUM); i++) stk_q[i] <= '0;
      end else begin
         tos_q   <= tos_d;
         depth_q <= depth_d;
         valid_q <= valid_d;
         stk_q   <= stk_d;
      end
   end

   assign valid = valid_q;
   assign pc    = PC_WIDTH'(tos_q.pc);
   assign mask  = THREAD_NUM'(tos_q.mask);
   assign depth = depth_q;

endmodule

// File: rtl/gelato_simt_stack.sv
// Per-warp SIMT reconvergence stacks with a shared update port and
// registered activate/overflow reporting.
module gelato_simt_stack
   import gelato_macros::*;
   import gelato_types::*;
#(
   parameter  int unsigned WARP_NUM    = GELATO_WARP_NUM,
   parameter  int unsigned THREAD_NUM  = GELATO_THREAD_NUM,
   parameter  int unsigned STACK_DEPTH = GELATO_STACK_DEPTH,
   parameter  int unsigned PC_WIDTH    = GELATO_PC_WIDTH,
   localparam int unsigned WARP_W      = $clog2(WARP_NUM),
   localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 rdy,
   input  logic                                 init_valid,
   input  logic [WARP_W-1:0]                    init_warp_num,
   input  logic [PC_WIDTH-1:0]                  init_pc,
   input  logic [THREAD_NUM-1:0]                init_mask,
   input  logic                                 upd_valid,
   input  logic [WARP_W-1:0]                    upd_warp_num,
   input  simt_op_t                             upd_op,
   input  logic [PC_WIDTH-1:0]                  upd_pc,
   input  logic [PC_WIDTH-1:0]                  upd_taken_pc,
   input  logic [THREAD_NUM-1:0]                upd_taken_mask,
   input  logic [PC_WIDTH-1:0]                  upd_reconv_pc,
   output logic [WARP_NUM-1:0]                  tbl_valid,
   output logic [WARP_NUM-1:0][PC_WIDTH-1:0]    tbl_pc,
   output logic [WARP_NUM-1:0][THREAD_NUM-1:0]  tbl_mask,
   output logic [WARP_NUM-1:0][DEPTH_W-1:0]     tbl_depth,
   output logic                                 activate_valid,
   output logic [WARP_W-1:0]                    activate_warp_num,
   output logic                                 overflow
);

   logic [WARP_NUM-1:0] ovf_c;
   logic                activate_valid_q, activate_valid_d;
   logic [WARP_W-1:0]   activate_warp_num_q, activate_warp_num_d;
   logic                overflow_q, overflow_d;

   for (genvar w = 0; w < int'(WARP_NUM); w++) begin : g_warp
      gelato_warp_simt_stack #(
         .STACK_DEPTH (STACK_DEPTH),
         .THREAD_NUM  (THREAD_NUM),
         .PC_WIDTH    (PC_WIDTH)
      ) u_stack (
         .clk            (clk),
         .rst_n          (rst_n),
         .rdy            (rdy),
         .init_valid     (init_valid && (init_warp_num == WARP_W'(w))),
         .init_pc        (init_pc),
         .init_mask      (init_mask),
         .upd_valid      (upd_valid && (upd_warp_num == WARP_W'(w))),
         .upd_op         (upd_op),
         .upd_pc         (upd_pc),
         .upd_taken_pc   (upd_taken_pc),
         .upd_taken_mask (upd_taken_mask),
         .upd_reconv_pc  (upd_reconv_pc),
         .valid          (tbl_valid[w]),
         .pc             (tbl_pc[w]),
         .mask           (tbl_mask[w]),
         .depth          (tbl_depth[w]),
         .overflow_c     (ovf_c[w])
      );
   end

   // Only one warp is updated per cycle, so at most one overflow source fires.
   always_comb begin
      activate_valid_d    = activate_valid_q;
      activate_warp_num_d = activate_warp_num_q;
      overflow_d          = overflow_q;
      if (rdy) begin
         activate_valid_d    = upd_valid && (upd_op != SIMT_NOP);
         activate_warp_num_d = upd_warp_num;
         overflow_d          = |ovf_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         activate_valid_q    <= 1'b0;
         activate_warp_num_q <= '0;
         overflow_q          <= 1'b0;
      end else begin
         activate_valid_q    <= activate_valid_d;
         activate_warp_num_q <= activate_warp_num_d;
         overflow_q          <= overflow_d;
      end
   end

   assign activate_valid    = activate_valid_q;
   assign activate_warp_num = activate_warp_num_q;
   assign overflow          = overflow_q;

endmodule

// File: tb/tb_gelato_simt_stack.sv
// Directed vector bench for gelato_simt_stack at default parameters.
module tb_gelato_simt_stack;
   import gelato_types::*;

   localparam logic [31:0] ALL = 32'hFFFF_FFFF;
   localparam logic [31:0] Z32 = 32'h0;

   logic              clk = 1'b0;
   logic              rst_n, rdy, init_valid, upd_valid;
   logic [1:0]        init_warp_num, upd_warp_num;
   logic [31:0]       init_pc, init_mask;
   simt_op_t          upd_op;
   logic [31:0]       upd_pc, upd_taken_pc, upd_taken_mask, upd_reconv_pc;
   logic [3:0]        tbl_valid;
   logic [3:0][31:0]  tbl_pc, tbl_mask;
   logic [3:0][3:0]   tbl_depth;
   logic              activate_valid, overflow;
   logic [1:0]        activate_warp_num;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        iv;   logic [1:0] iw;  logic [31:0] ipc; logic [31:0] imask;
      logic        uv;   logic [1:0] uw;  simt_op_t    op;
      logic [31:0] upc;  logic [31:0] utpc; logic [31:0] utm; logic [31:0] urpc;
      logic [1:0]  cw;   logic [3:0] evv; logic [31:0] epc; logic [31:0] emask;
      logic [3:0]  edep; logic eact; logic eovf;
   } vec_t;

   vec_t vecs[22];

   gelato_simt_stack dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .rdy               (rdy),
      .init_valid        (init_valid),
      .init_warp_num     (init_warp_num),
      .init_pc           (init_pc),
      .init_mask         (init_mask),
      .upd_valid         (upd_valid),
      .upd_warp_num      (upd_warp_num),
      .upd_op            (upd_op),
      .upd_pc            (upd_pc),
      .upd_taken_pc      (upd_taken_pc),
      .upd_taken_mask    (upd_taken_mask),
      .upd_reconv_pc     (upd_reconv_pc),
      .tbl_valid         (tbl_valid),
      .tbl_pc            (tbl_pc),
      .tbl_mask          (tbl_mask),
      .tbl_depth         (tbl_depth),
      .activate_valid    (activate_valid),
      .activate_warp_num (activate_warp_num),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic iv, input logic [1:0] iw, input logic [31:0] ipc, input logic [31:0] imask,
      input logic uv, input logic [1:0] uw, input simt_op_t op,
      input logic [31:0] upc, input logic [31:0] utpc, input logic [31:0] utm,
      input logic [31:0] urpc, input logic [1:0] cw, input logic [3:0] evv,
      input logic [31:0] epc, input logic [31:0] emask, input logic [3:0] edep,
      input logic eact, input logic eovf);
      vec_t v;
      v.iv = iv; v.iw = iw; v.ipc = ipc; v.imask = imask;
      v.uv = uv; v.uw = uw; v.op = op;
      v.upc = upc; v.utpc = utpc; v.utm = utm; v.urpc = urpc;
      v.cw = cw; v.evv = evv; v.epc = epc; v.emask = emask; v.edep = edep;
      v.eact = eact; v.eovf = eovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      init_valid = 1'b0; init_warp_num = 2'd0; init_pc = Z32; init_mask = Z32;
      upd_valid = 1'b0; upd_warp_num = 2'd0; upd_op = SIMT_NOP;
      upd_pc = Z32; upd_taken_pc = Z32; upd_taken_mask = Z32; upd_reconv_pc = Z32;
   endtask

   task automatic chk_warp(input string tag, input logic [1:0] w, input logic [31:0] epc,
                           input logic [31:0] emask, input logic [3:0] edep);
      chk({tag, ".pc"},    tbl_pc[w], epc);
      chk({tag, ".mask"},  tbl_mask[w], emask);
      chk({tag, ".depth"}, 32'(tbl_depth[w]), 32'(edep));
   endtask

   initial begin
      //          iv    iw    ipc        imask         uv    uw    op            upc        utpc       utm            urpc       cw    evv      epc        emask          dep   act   ovf
      vecs[0]  = mk(1'b1, 2'd2, 32'h100, ALL,          1'b0, 2'd0, SIMT_NOP,     Z32,       Z32,       Z32,           Z32,       2'd2, 4'b0100, 32'h100,   ALL,           4'd1, 1'b0, 1'b0);
      vecs[1]  = mk(1'b1, 2'd0, 32'h100, ALL,          1'b0, 2'd0, SIMT_NOP,     Z32,       Z32,       Z32,           Z32,       2'd0, 4'b0101, 32'h100,   ALL,           4'd1, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_BRANCH,  32'h104,   32'h200,   32'h0000_FFFF, 32'h300,   2'd0, 4'b0101, 32'h200,   32'h0000_FFFF, 4'd3, 1'b1, 1'b0);
      vecs[3]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_ADVANCE, 32'h300,   Z32,       Z32,           Z32,       2'd0, 4'b0101, 32'h104,   32'hFFFF_0000, 4'd2, 1'b1, 1'b0);
      vecs[4]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_ADVANCE, 32'h300,   Z32,       Z32,           Z32,       2'd0, 4'b0101, 32'h300,   ALL,           4'd1, 1'b1, 1'b0);
      vecs[5]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_ADVANCE, 32'h304,   Z32,       Z32,           Z32,       2'd0, 4'b0101, 32'h304,   ALL,           4'd1, 1'b1, 1'b0);
      vecs[6]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_BRANCH,  32'h308,   32'h400,   ALL,           32'h500,   2'd0, 4'b0101, 32'h400,   ALL,           4'd1, 1'b1, 1'b0);
      vecs[7]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_BRANCH,  32'h404,   32'h600,   Z32,           32'h700,   2'd0, 4'b0101, 32'h404,   ALL,           4'd1, 1'b1, 1'b0);
      vecs[8]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_NOP,     32'h999,   Z32,       Z32,           Z32,       2'd0, 4'b0101, 32'h404,   ALL,           4'd1, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd3, SIMT_ADVANCE, 32'h50,    Z32,       Z32,           Z32,       2'd3, 4'b0101, Z32,       Z32,           4'd0, 1'b1, 1'b0);
      vecs[10] = mk(1'b1, 2'd3, 32'h55,  Z32,          1'b0, 2'd0, SIMT_NOP,     Z32,       Z32,       Z32,           Z32,       2'd3, 4'b0101, Z32,       Z32,           4'd0, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd2, SIMT_EXIT,    Z32,       Z32,       Z32,           Z32,       2'd2, 4'b0001, Z32,       Z32,           4'd0, 1'b1, 1'b0);
      vecs[12] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_BRANCH,  32'h410,   32'h420,   32'h0000_FFFF, 32'h430,   2'd0, 4'b0001, 32'h420,   32'h0000_FFFF, 4'd3, 1'b1, 1'b0);
      vecs[13] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_BRANCH,  32'h440,   32'h450,   32'h0000_00FF, 32'h460,   2'd0, 4'b0001, 32'h450,   32'h0000_00FF, 4'd5, 1'b1, 1'b0);
      vecs[14] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_BRANCH,  32'h470,   32'h480,   32'h0000_000F, 32'h490,   2'd0, 4'b0001, 32'h480,   32'h0000_000F, 4'd7, 1'b1, 1'b0);
      vecs[15] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_BRANCH,  32'h4a0,   32'h4b0,   32'h0000_0003, 32'h4c0,   2'd0, 4'b0001, 32'h480,   32'h0000_000F, 4'd7, 1'b1, 1'b1);
      vecs[16] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_NOP,     Z32,       Z32,       Z32,           Z32,       2'd0, 4'b0001, 32'h480,   32'h0000_000F, 4'd7, 1'b0, 1'b0);
      vecs[17] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_ADVANCE, 32'h490,   Z32,       Z32,           Z32,       2'd0, 4'b0001, 32'h470,   32'h0000_00F0, 4'd6, 1'b1, 1'b0);
      vecs[18] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd0, SIMT_ADVANCE, 32'h490,   Z32,       Z32,           Z32,       2'd0, 4'b0001, 32'h490,   32'h0000_00FF, 4'd5, 1'b1, 1'b0);
      vecs[19] = mk(1'b1, 2'd1, 32'h600, ALL,          1'b0, 2'd0, SIMT_NOP,     Z32,       Z32,       Z32,           Z32,       2'd1, 4'b0011, 32'h600,   ALL,           4'd1, 1'b0, 1'b0);
      vecs[20] = mk(1'b1, 2'd1, 32'h700, 32'hF0F0_F0F0, 1'b1, 2'd1, SIMT_BRANCH, 32'h704,   32'h800,   32'h0000_FFFF, 32'h900,   2'd1, 4'b0011, 32'h700,   32'hF0F0_F0F0, 4'd1, 1'b1, 1'b0);
      vecs[21] = mk(1'b0, 2'd0, Z32,     Z32,          1'b1, 2'd1, SIMT_NOP,     Z32,       Z32,       Z32,           Z32,       2'd1, 4'b0011, 32'h700,   32'hF0F0_F0F0, 4'd1, 1'b0, 1'b0);

      rst_n = 1'b0;
      rdy   = 1'b1;
      idle_inputs();
      step();
      step();
      chk("rst.valid", 32'(tbl_valid), 32'h0);
      chk("rst.act",   32'(activate_valid), 32'h0);
      chk("rst.ovf",   32'(overflow), 32'h0);
      chk_warp("rst.w0", 2'd0, Z32, Z32, 4'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         init_valid = vecs[i].iv; init_warp_num = vecs[i].iw;
         init_pc = vecs[i].ipc;   init_mask = vecs[i].imask;
         upd_valid = vecs[i].uv;  upd_warp_num = vecs[i].uw; upd_op = vecs[i].op;
         upd_pc = vecs[i].upc;    upd_taken_pc = vecs[i].utpc;
         upd_taken_mask = vecs[i].utm; upd_reconv_pc = vecs[i].urpc;
         step();
         chk($sformatf("v%0d.valid", i), 32'(tbl_valid), 32'(vecs[i].evv));
         chk_warp($sformatf("v%0d", i), vecs[i].cw, vecs[i].epc, vecs[i].emask, vecs[i].edep);
         chk($sformatf("v%0d.act", i), 32'(activate_valid), 32'(vecs[i].eact));
         if (vecs[i].eact)
            chk($sformatf("v%0d.actw", i), 32'(activate_warp_num), 32'(vecs[i].uw));
         chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(vecs[i].eovf));
      end

      // Divergent branch held on the port while rdy is low: nothing may move.
      idle_inputs();
      rdy = 1'b0;
      upd_valid = 1'b1; upd_warp_num = 2'd1; upd_op = SIMT_BRANCH;
      upd_pc = 32'h704; upd_taken_pc = 32'h800;
      upd_taken_mask = 32'h0000_FFFF; upd_reconv_pc = 32'h900;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_warp($sformatf("frz%0d", c), 2'd1, 32'h700, 32'hF0F0_F0F0, 4'd1);
         chk($sformatf("frz%0d.act", c), 32'(activate_valid), 32'h0);
      end
      rdy = 1'b1;
      step();
      chk_warp("thaw", 2'd1, 32'h800, 32'h0000_F0F0, 4'd3);
      chk("thaw.act", 32'(activate_valid), 32'h1);

      // Asynchronous reset in the middle of a clock period at depth 3.
      idle_inputs();
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.valid", 32'(tbl_valid), 32'h0);
      chk("arst.act",   32'(activate_valid), 32'h0);
      chk_warp("arst.w1", 2'd1, Z32, Z32, 4'd0);
      chk("arst.w0.depth", 32'(tbl_depth[0]), 32'h0);
      #3;
      rst_n = 1'b1;
      init_valid = 1'b1; init_warp_num = 2'd1; init_pc = 32'hA00; init_mask = 32'h1;
      step();
      idle_inputs();
      chk("post.valid", 32'(tbl_valid), 32'h2);
      chk_warp("post.w1", 2'd1, 32'hA00, 32'h1, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
